// File: rtl/lsu.sv
// Load/store unit: single outstanding data-bus access, byte-lane steering for
// stores, lane select plus sign/zero extension for loads, misalignment trap.
module lsu #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            issue,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] result,
   input  logic [XLEN-1:0] reg_out,
   input  logic            mm_we,
   input  logic            passthrough,
   output logic [XLEN-1:0] rd_data,
   output logic            mem_stall,
   output logic            misaligned,
   output logic            dbus_req,
   output logic            dbus_we,
   output logic [XLEN-1:0] dbus_addr,
   output logic [3:0]      dbus_be,
   output logic [XLEN-1:0] dbus_wdata,
   input  logic            dbus_ack,
   input  logic [XLEN-1:0] dbus_rdata
);

   // Bus handshake: dbus_req acts as valid and dbus_ack as ready. Once raised,
   // dbus_req and every qualifier (we/addr/be/wdata) hold stable until the
   // cycle in which dbus_ack is sampled high in BUSY; the transfer completes
   // on that edge and dbus_req drops there. Acks outside BUSY are ignored.

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t state;
   state_t next_state;

   logic [1:0] lane;
   logic       op_store;
   logic       illegal;
   logic       unaligned;
   logic       bad_access;
   logic       accept;
   logic       start_mem;
   logic       finish_mem;

   // Captured at issue so the load can be formatted when the ack arrives.
   logic [2:0] op_funct3;
   logic [1:0] op_lane;
   logic       op_load;

   function automatic logic [3:0] lane_enables(input logic [1:0] size,
                                               input logic [1:0] a);
      logic [3:0] be;
      case (size)
         2'b00:   be = 4'b0001 << a;
         2'b01:   be = 4'b0011 << a;
         default: be = 4'b1111;
      endcase
      return be;
   endfunction

   function automatic logic [XLEN-1:0] steer_wdata(input logic [1:0]      size,
                                                   input logic [XLEN-1:0] d);
      logic [XLEN-1:0] w;
      case (size)
         2'b00:   w = {4{d[7:0]}};
         2'b01:   w = {2{d[15:0]}};
         default: w = d;
      endcase
      return w;
   endfunction

   function automatic logic [XLEN-1:0] format_load(input logic [2:0]      f3,
                                                   input logic [1:0]      a,
                                                   input logic [XLEN-1:0] rdata);
      logic [7:0]      b;
      logic [15:0]     h;
      logic [XLEN-1:0] v;
      b = rdata[{a, 3'b000} +: 8];
      h = a[1] ? rdata[31:16] : rdata[15:0];
      case (f3)
         3'b000:  v = {{24{b[7]}}, b};
         3'b001:  v = {{16{h[15]}}, h};
         3'b100:  v = {24'h0, b};
         3'b101:  v = {16'h0, h};
         default: v = rdata;
      endcase
      return v;
   endfunction

   assign lane     = result[1:0];
   assign op_store = !passthrough && mm_we;

   // Size code 11 and funct3 110 are reserved; stores have no unsigned forms.
   assign illegal    = (funct3[1:0] == 2'b11) || (funct3 == 3'b110) ||
                       (op_store && funct3[2]);
   assign unaligned  = ((funct3[1:0] == 2'b01) && lane[0]) ||
                       ((funct3[1:0] == 2'b10) && (lane != 2'b00));
   assign bad_access = illegal || unaligned;

   assign accept     = (state == IDLE) && issue;
   assign start_mem  = accept && !passthrough && !bad_access;
   assign finish_mem = (state == BUSY) && dbus_ack;

   assign mem_stall  = (state == BUSY);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: if (start_mem)  next_state = BUSY;
         BUSY: if (finish_mem) next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data    <= '0;
         misaligned <= 1'b0;
         dbus_req   <= 1'b0;
         dbus_we    <= 1'b0;
         dbus_addr  <= '0;
         dbus_be    <= 4'b0000;
         dbus_wdata <= '0;
         op_funct3  <= 3'b000;
         op_lane    <= 2'b00;
         op_load    <= 1'b0;
      end else begin
         misaligned <= 1'b0;
         if (accept) begin
            if (passthrough) begin
               rd_data <= result;
            end else if (bad_access) begin
               misaligned <= 1'b1;
               rd_data    <= '0;
            end else begin
               dbus_req   <= 1'b1;
               dbus_we    <= mm_we;
               dbus_addr  <= {result[XLEN-1:2], 2'b00};
               dbus_be    <= lane_enables(funct3[1:0], lane);
               dbus_wdata <= steer_wdata(funct3[1:0], reg_out);
               op_funct3  <= funct3;
               op_lane    <= lane;
               op_load    <= !mm_we;
            end
         end else if (finish_mem) begin
            dbus_req <= 1'b0;
            dbus_we  <= 1'b0;
            rd_data  <= op_load ? format_load(op_funct3, op_lane, dbus_rdata) : '0;
         end
      end
   end

endmodule

// File: tb/tb_lsu.sv
// Directed and randomized checks of lsu: ALU writeback, loads/stores with
// variable ack latency, misaligned/illegal traps, and asynchronous reset.
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue;
   logic [2:0]  funct3;
   logic [31:0] result;
   logic [31:0] reg_out;
   logic        mm_we;
   logic        passthrough;
   logic [31:0] rd_data;
   logic        mem_stall;
   logic        misaligned;
   logic        dbus_req;
   logic        dbus_we;
   logic [31:0] dbus_addr;
   logic [3:0]  dbus_be;
   logic [31:0] dbus_wdata;
   logic        dbus_ack;
   logic [31:0] dbus_rdata;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   lsu #(.XLEN(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .issue      (issue),
      .funct3     (funct3),
      .result     (result),
      .reg_out    (reg_out),
      .mm_we      (mm_we),
      .passthrough(passthrough),
      .rd_data    (rd_data),
      .mem_stall  (mem_stall),
      .misaligned (misaligned),
      .dbus_req   (dbus_req),
      .dbus_we    (dbus_we),
      .dbus_addr  (dbus_addr),
      .dbus_be    (dbus_be),
      .dbus_wdata (dbus_wdata),
      .dbus_ack   (dbus_ack),
      .dbus_rdata (dbus_rdata)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_rd(input string tag);
      logic [31:0] e;
      if (exp_q.size() == 0) begin
         checks++;
         errors++;
         $error("FAIL %s observed=empty_queue expected=entry", tag);
      end else begin
         e = exp_q.pop_front();
         chk(tag, rd_data, e);
      end
   endtask

   // reference model, built lane by lane
   function automatic int nbytes(input logic [2:0] f3);
      return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [1:0] a);
      logic [3:0] be = 4'b0000;
      for (int i = 0; i < 4; i++)
         if (i >= int'(a) && i < int'(a) + nbytes(f3)) be[i] = 1'b1;
      return be;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
      logic [31:0] w = '0;
      for (int i = 0; i < 4; i++) w[i*8 +: 8] = d[(i % nbytes(f3))*8 +: 8];
      return w;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] a,
                                              input logic [31:0] rdata);
      logic [31:0] v = '0;
      int n = nbytes(f3);
      for (int i = 0; i < n; i++) v[i*8 +: 8] = rdata[(int'(a) + i)*8 +: 8];
      if (!f3[2] && v[n*8-1])
         for (int i = n*8; i < 32; i++) v[i] = 1'b1;
      return v;
   endfunction

   // driver tasks
   task automatic drive_idle();
      issue = 1'b0; funct3 = 3'b000; result = '0; reg_out = '0;
      mm_we = 1'b0; passthrough = 1'b0;
   endtask

   task automatic do_alu(input logic [31:0] val);
      @(negedge clk);
      issue = 1'b1; passthrough = 1'b1; mm_we = 1'b0; result = val;
      exp_q.push_back(val);
      @(negedge clk);
      drive_idle();
      chk_rd("alu_rd");
      chk("alu_stall", mem_stall, 0);
      chk("alu_req", dbus_req, 0);
   endtask

   task automatic do_mem(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [31:0] rdata, input int n_busy,
                         input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                         input logic [31:0] exp_rd);
      int stalls = 0;
      @(negedge clk);
      issue = 1'b1; passthrough = 1'b0; mm_we = we; funct3 = f3;
      result = addr; reg_out = sdata;
      exp_q.push_back(exp_rd);
      @(negedge clk);
      drive_idle();
      chk("mem_req", dbus_req, 1);
      chk("mem_we", dbus_we, we);
      chk("mem_addr", dbus_addr, {addr[31:2], 2'b00});
      chk("mem_be", dbus_be, exp_be);
      if (we) chk("mem_wdata", dbus_wdata, exp_wdata);
      for (int i = 0; i < 50 && mem_stall; i++) begin
         stalls++;
         chk("mem_addr_hold", dbus_addr, {addr[31:2], 2'b00});
         if (stalls == n_busy) begin
            dbus_ack = 1'b1;
            dbus_rdata = rdata;
         end
         @(negedge clk);
         dbus_ack = 1'b0;
         dbus_rdata = $urandom();
      end
      chk("mem_stall_cycles", stalls, n_busy);
      chk("mem_stall_end", mem_stall, 0);
      chk("mem_req_end", dbus_req, 0);
      chk("mem_we_end", dbus_we, 0);
      chk_rd("mem_rd");
   endtask

   task automatic do_bad(input logic we, input logic [2:0] f3, input logic [31:0] addr);
      @(negedge clk);
      issue = 1'b1; passthrough = 1'b0; mm_we = we; funct3 = f3; result = addr;
      exp_q.push_back(32'h0);
      @(negedge clk);
      drive_idle();
      chk("bad_misaligned", misaligned, 1);
      chk("bad_req", dbus_req, 0);
      chk("bad_stall", mem_stall, 0);
      chk_rd("bad_rd");
      @(negedge clk);
      chk("bad_pulse_end", misaligned, 0);
      chk("bad_req_after", dbus_req, 0);
   endtask

   // stimulus
   initial begin
      drive_idle();
      dbus_ack = 1'b0;
      dbus_rdata = '0;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_rd", rd_data, 0);
      chk("rst_stall", mem_stall, 0);
      chk("rst_mis", misaligned, 0);
      chk("rst_req", dbus_req, 0);
      chk("rst_we", dbus_we, 0);
      chk("rst_addr", dbus_addr, 0);
      chk("rst_be", {28'h0, dbus_be}, 0);
      chk("rst_wdata", dbus_wdata, 0);
      rst = 1'b0;

      do_alu(32'h12345678);
      do_mem(1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80AA_5511, 2,
             4'b1000, 32'h0, 32'hFFFF_FF80);
      do_mem(1'b1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 32'h0, 1,
             4'b1100, 32'hABCD_ABCD, 32'h0);
      do_mem(1'b0, 3'b101, 32'h0000_4002, 32'h0, 32'hBEEF_1234, 1,
             4'b1100, 32'h0, 32'h0000_BEEF);
      do_bad(1'b0, 3'b010, 32'h0000_3001);
      do_alu(32'hCAFE_0001);
      do_bad(1'b0, 3'b001, 32'h0000_3003);
      do_bad(1'b0, 3'b011, 32'h0000_3000);
      do_alu(32'h0000_0042);
      do_bad(1'b1, 3'b100, 32'h0000_3000);
      do_mem(1'b0, 3'b010, 32'h0000_5000, 32'h0, 32'hDEAD_BEEF, 3,
             4'b1111, 32'h0, 32'hDEAD_BEEF);
      do_mem(1'b0, 3'b001, 32'h0000_6002, 32'h0, 32'h8001_7FFF, 1,
             4'b1100, 32'h0, 32'hFFFF_8001);

      for (int k = 0; k < 10; k++) begin
         logic        we;
         logic [2:0]  f3;
         logic [31:0] addr;
         logic [31:0] sd;
         logic [31:0] rdw;
         logic [2:0]  ld_codes [5];
         ld_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
         we = 1'($urandom_range(0, 1));
         f3 = we ? 3'($urandom_range(0, 2)) : ld_codes[$urandom_range(0, 4)];
         addr = $urandom();
         if (f3[1:0] == 2'b01) addr[0] = 1'b0;
         if (f3[1:0] == 2'b10) addr[1:0] = 2'b00;
         sd = $urandom();
         rdw = $urandom();
         do_mem(we, f3, addr, sd, rdw, $urandom_range(1, 4), model_be(f3, addr[1:0]),
                model_wdata(f3, sd), we ? 32'h0 : model_load(f3, addr[1:0], rdw));
      end

      // asynchronous reset in the middle of an outstanding access
      @(negedge clk);
      issue = 1'b1; passthrough = 1'b0; mm_we = 1'b0; funct3 = 3'b010; result = 32'h0000_7000;
      @(negedge clk);
      drive_idle();
      chk("mid_req_before", dbus_req, 1);
      chk("mid_stall_before", mem_stall, 1);
      #2 rst = 1'b1;
      #1;
      chk("mid_req_async", dbus_req, 0);
      chk("mid_stall_async", mem_stall, 0);
      chk("mid_rd_async", rd_data, 0);
      @(negedge clk);
      rst = 1'b0;
      dbus_ack = 1'b1;
      dbus_rdata = 32'h1111_2222;
      @(negedge clk);
      dbus_ack = 1'b0;
      chk("late_ack_stall", mem_stall, 0);
      chk("late_ack_req", dbus_req, 0);
      chk("late_ack_rd", rd_data, 0);
      do_alu(32'h0BAD_F00D);

      chk("queue_drained", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
